// File: rtl/pll_lock_supervisor.sv
// Lock supervisor for a bank of PLLs: synchronises each locked flag, pulses the PLL
// reset, debounces lock, retries on timeout or lock loss and latches a fault after too many tries.
module pll_lock_supervisor #(
    parameter int NUM_PLLS           = 2,
    parameter int RESET_PULSE_CYCLES = 16,
    parameter int DEBOUNCE_CYCLES    = 1024,
    parameter int LOCK_TIMEOUT       = 125000,
    parameter int MAX_RETRIES        = 3,
    parameter int RETRY_W            = $clog2(MAX_RETRIES + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PLLS-1:0]           pll_locked_async,
    input  logic [NUM_PLLS-1:0]           clear_fault,
    output logic [NUM_PLLS-1:0]           pll_reset,
    output logic [NUM_PLLS-1:0]           pll_ok,
    output logic [NUM_PLLS-1:0]           fault,
    output logic [NUM_PLLS*RETRY_W-1:0]   retry_count,
    output logic                          all_ok,
    output logic                          sys_reset
);

    localparam int RST_W = $clog2(RESET_PULSE_CYCLES) + 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TO_W  = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    logic [NUM_PLLS-1:0] sync1_reg;
    logic [NUM_PLLS-1:0] sync2_reg;
    logic                all_ok_reg;
    logic                sys_reset_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= pll_locked_async;
            sync2_reg <= sync1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PLLS; gi++) begin : g_chan
            state_t             state_reg;
            logic [RST_W-1:0]   rst_cnt_reg;
            logic [DEB_W-1:0]   deb_cnt_reg;
            logic [TO_W-1:0]    to_cnt_reg;
            logic [RETRY_W-1:0] retry_reg;
            logic [RETRY_W-1:0] retry_next;
            state_t             fail_state;
            logic               lock_s;

            assign lock_s     = sync2_reg[gi];
            assign retry_next = (retry_reg == RETRY_MAX) ? RETRY_MAX : retry_reg + 1'b1;
            // A clear arriving with the failing attempt restarts the count, so it cannot fault.
            assign fail_state = (!clear_fault[gi] && retry_next == RETRY_MAX) ? ST_FAULT : ST_RESET;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg   <= ST_RESET;
                    rst_cnt_reg <= '0;
                    deb_cnt_reg <= '0;
                    to_cnt_reg  <= '0;
                    retry_reg   <= '0;
                end else begin
                    case (state_reg)
                        ST_RESET: begin
                            if (rst_cnt_reg == RST_LAST) begin
                                state_reg   <= ST_WAIT_LOCK;
                                deb_cnt_reg <= '0;
                                to_cnt_reg  <= '0;
                            end else begin
                                rst_cnt_reg <= rst_cnt_reg + 1'b1;
                            end
                        end
                        ST_WAIT_LOCK: begin
                            to_cnt_reg  <= to_cnt_reg + 1'b1;
                            deb_cnt_reg <= lock_s ? deb_cnt_reg + 1'b1 : '0;
                            // Debounce completion takes priority over a coincident timeout.
                            if (lock_s && deb_cnt_reg == DEB_LAST) begin
                                state_reg <= ST_LOCKED;
                            end else if (to_cnt_reg == TO_LAST) begin
                                state_reg   <= fail_state;
                                rst_cnt_reg <= '0;
                                retry_reg   <= retry_next;
                            end
                        end
                        ST_LOCKED: begin
                            if (!lock_s) begin
                                state_reg   <= fail_state;
                                rst_cnt_reg <= '0;
                                retry_reg   <= retry_next;
                            end
                        end
                        ST_FAULT: begin
                            if (clear_fault[gi]) begin
                                state_reg   <= ST_RESET;
                                rst_cnt_reg <= '0;
                            end
                        end
                        default: begin
                            state_reg   <= ST_RESET;
                            rst_cnt_reg <= '0;
                        end
                    endcase
                    if (clear_fault[gi]) begin
                        retry_reg <= '0;
                    end
                end
            end

            assign pll_reset[gi] = (state_reg == ST_RESET) || (state_reg == ST_FAULT);
            assign pll_ok[gi]    = (state_reg == ST_LOCKED);
            assign fault[gi]     = (state_reg == ST_FAULT);
            assign retry_count[gi*RETRY_W +: RETRY_W] = retry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            all_ok_reg    <= 1'b0;
            sys_reset_reg <= 1'b1;
        end else begin
            all_ok_reg    <= &pll_ok;
            sys_reset_reg <= ~(&pll_ok);
        end
    end

    assign all_ok    = all_ok_reg;
    assign sys_reset = sys_reset_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed and randomised bench for pll_lock_supervisor, checked every cycle against a
// timestamp-based reference model of the lock/retry rules.
module tb_pll_lock_supervisor;

    localparam int NP  = 2;
    localparam int RPC = 3;
    localparam int DEB = 4;
    localparam int LT  = 32;
    localparam int MR  = 2;
    localparam int RW  = $clog2(MR + 1);

    localparam int P_PULSE = 0;
    localparam int P_WAIT  = 1;
    localparam int P_LOCK  = 2;
    localparam int P_FAULT = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     pll_locked_async;
    logic [NP-1:0]     clear_fault;
    logic [NP-1:0]     pll_reset;
    logic [NP-1:0]     pll_ok;
    logic [NP-1:0]     fault;
    logic [NP*RW-1:0]  retry_count;
    logic              all_ok;
    logic              sys_reset;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .NUM_PLLS          (NP),
        .RESET_PULSE_CYCLES(RPC),
        .DEBOUNCE_CYCLES   (DEB),
        .LOCK_TIMEOUT      (LT),
        .MAX_RETRIES       (MR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_locked_async(pll_locked_async),
        .clear_fault     (clear_fault),
        .pll_reset       (pll_reset),
        .pll_ok          (pll_ok),
        .fault           (fault),
        .retry_count     (retry_count),
        .all_ok          (all_ok),
        .sys_reset       (sys_reset)
    );

    // Model: each channel has a phase, the edge it entered that phase and its retry tally.
    int phase     [NP];
    int start     [NP];
    int last_zero [NP];
    int retries   [NP];
    bit d1_lock   [NP];
    bit d2_lock   [NP];
    bit d1_rst = 1'b1;
    bit d2_rst = 1'b1;
    bit exp_all_ok = 1'b0;
    int k = 0;
    int vectors = 0;
    int miscompares = 0;

    function automatic bit model_all_locked();
        bit r = 1'b1;
        for (int c = 0; c < NP; c++) r &= (phase[c] == P_LOCK);
        return r;
    endfunction

    task automatic fail_attempt(input int c, input bit clr, input int now);
        int nr;
        nr = clr ? 0 : ((retries[c] + 1 > MR) ? MR : retries[c] + 1);
        retries[c] = nr;
        phase[c]   = (nr == MR) ? P_FAULT : P_PULSE;
        start[c]   = now;
    endtask

    task automatic model_edge();
        bit ls [NP];
        k++;
        for (int c = 0; c < NP; c++) ls[c] = (d1_rst || d2_rst) ? 1'b0 : d2_lock[c];
        if (reset) begin
            for (int c = 0; c < NP; c++) begin
                phase[c] = P_PULSE;
                start[c] = k;
                retries[c] = 0;
            end
            exp_all_ok = 1'b0;
        end else begin
            exp_all_ok = model_all_locked();
            for (int c = 0; c < NP; c++) begin
                int run;
                bit was_fault;
                was_fault = (phase[c] == P_FAULT);
                if (!ls[c]) last_zero[c] = k;
                run = ls[c] ? k - ((last_zero[c] > start[c]) ? last_zero[c] : start[c]) : 0;
                case (phase[c])
                    P_PULSE: if (k - start[c] == RPC) begin
                        phase[c] = P_WAIT;
                        start[c] = k;
                    end
                    P_WAIT: begin
                        if (run == DEB) begin
                            phase[c] = P_LOCK;
                            start[c] = k;
                        end else if (k - start[c] == LT) begin
                            fail_attempt(c, clear_fault[c], k);
                        end
                    end
                    P_LOCK: if (!ls[c]) fail_attempt(c, clear_fault[c], k);
                    default: if (clear_fault[c]) begin
                        phase[c] = P_PULSE;
                        start[c] = k;
                        retries[c] = 0;
                    end
                endcase
                if (clear_fault[c] && !was_fault) retries[c] = 0;
            end
        end
        for (int c = 0; c < NP; c++) begin
            d2_lock[c] = d1_lock[c];
            d1_lock[c] = pll_locked_async[c];
        end
        d2_rst = d1_rst;
        d1_rst = reset;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s edge %0d got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [NP-1:0]    e_rst;
        logic [NP-1:0]    e_ok;
        logic [NP-1:0]    e_fault;
        logic [NP*RW-1:0] e_retry;
        for (int c = 0; c < NP; c++) begin
            e_rst[c]   = (phase[c] == P_PULSE) || (phase[c] == P_FAULT);
            e_ok[c]    = (phase[c] == P_LOCK);
            e_fault[c] = (phase[c] == P_FAULT);
            e_retry[c*RW +: RW] = RW'(retries[c]);
        end
        chk("pll_reset",   8'(pll_reset),   8'(e_rst));
        chk("pll_ok",      8'(pll_ok),      8'(e_ok));
        chk("fault",       8'(fault),       8'(e_fault));
        chk("retry_count", 8'(retry_count), 8'(e_retry));
        chk("all_ok",      8'(all_ok),      8'(exp_all_ok));
        chk("sys_reset",   8'(sys_reset),   8'(!exp_all_ok));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        for (int c = 0; c < NP; c++) begin
            phase[c] = P_PULSE;
            start[c] = 0;
            last_zero[c] = 0;
            retries[c] = 0;
            d1_lock[c] = 1'b0;
            d2_lock[c] = 1'b0;
        end
        reset = 1'b1;
        pll_locked_async = '0;
        clear_fault = '0;
        repeat (3) tick();

        // Clean lock on channel 1, glitchy lock on channel 0
        reset = 1'b0;
        pll_locked_async[1] = 1'b1;
        repeat (4 + $urandom_range(0, 2)) tick();
        pll_locked_async[0] = 1'b1;
        repeat (3) tick();
        pll_locked_async[0] = 1'b0;
        tick();
        pll_locked_async[0] = 1'b1;
        repeat (14) tick();

        // Loss of lock, then reset while the retry attempt is waiting
        pll_locked_async[0] = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        pll_locked_async[0] = 1'b1;
        repeat (20) tick();

        // Lose lock then time out: second failure latches the fault
        pll_locked_async[0] = 1'b0;
        repeat (110) tick();

        // Clear the fault and let channel 0 lock again
        clear_fault = 2'b01;
        tick();
        clear_fault = '0;
        pll_locked_async[0] = 1'b1;
        repeat (25) tick();

        // Randomised lock behaviour, clears and occasional resets
        for (int i = 0; i < 900; i++) begin
            for (int c = 0; c < NP; c++) begin
                if (pll_locked_async[c])
                    pll_locked_async[c] = ($urandom_range(0, 29) != 0);
                else
                    pll_locked_async[c] = ($urandom_range(0, 5) == 0);
                clear_fault[c] = ($urandom_range(0, 49) == 0);
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        clear_fault = '0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
